// File: rtl/chip8_sprite_draw.sv
// chip8_sprite_draw
//   Executes CHIP-8 DRAW (DXYN) and CLEAR (00E0) against an external
//   memory port that holds both sprite RAM and a 1 bpp VRAM. There is at
//   most one memory request outstanding at a time.
//
//   Build option: define CHIP8_DRAW_WRAP_EN to wrap sprites at the screen
//   edges (rows modulo SCREEN_H, right byte modulo ROW_BYTES). Leave it
//   undefined to clip instead (rows past the bottom and the byte past the
//   right edge are skipped).
//
// Parameters
//   SCREEN_H  : display height in rows (power of two)
//   ROW_BYTES : bytes per VRAM row (MSB of a byte = leftmost pixel)
//
// Ports
//   clk_in, rst_in (synchronous, active-low)
//   cmd_valid_in / cmd_ready_out : command handshake
//   cmd_op_in (0 DRAW, 1 CLEAR), cmd_x_in, cmd_y_in, cmd_n_in, cmd_i_in
//   done_out      : one-cycle completion pulse
//   collision_out : VF result, held until the next command is accepted
//   mem_valid_out / mem_ready_in : request handshake
//   mem_we_out, mem_type_out (0 RAM, 1 VRAM), mem_addr_out, mem_data_out
//   mem_rvalid_in, mem_rdata_in (low byte) : read return
module chip8_sprite_draw #(
  parameter int SCREEN_H  = 32,
  parameter int ROW_BYTES = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        cmd_valid_in,
  output logic        cmd_ready_out,
  input  logic        cmd_op_in,
  input  logic [7:0]  cmd_x_in,
  input  logic [7:0]  cmd_y_in,
  input  logic [3:0]  cmd_n_in,
  input  logic [11:0] cmd_i_in,
  output logic        done_out,
  output logic        collision_out,
  output logic        mem_valid_out,
  output logic        mem_we_out,
  output logic        mem_type_out,
  output logic [15:0] mem_addr_out,
  output logic [15:0] mem_data_out,
  input  logic        mem_ready_in,
  input  logic        mem_rvalid_in,
  input  logic [15:0] mem_rdata_in
);

  localparam logic [7:0]  Y_MASK   = 8'(SCREEN_H - 1);
  localparam logic [8:0]  SH9      = 9'(SCREEN_H);
  localparam logic [7:0]  LAST_COL = 8'(ROW_BYTES - 1);
  localparam logic [15:0] RB16     = 16'(ROW_BYTES);
  localparam logic [15:0] CLR_LAST = 16'(SCREEN_H * ROW_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SPR_RD, S_L_RD, S_L_WR, S_R_RD, S_R_WR, S_CLR_WR, S_FINISH
  } state_t;

  // control state (reset)
  state_t      state_q, state_d;
  logic        acc_q, acc_d;     // read accepted, waiting for its return
  logic        coll_q, coll_d;
  // working data (no reset needed; loaded at command acceptance)
  logic [7:0]  col_q, col_d;
  logic [2:0]  off_q, off_d;
  logic [7:0]  y_q, y_d;
  logic [3:0]  rows_q, rows_d;
  logic [11:0] iaddr_q, iaddr_d;
  logic [7:0]  spr_q, spr_d;
  logic [7:0]  vdat_q, vdat_d;
  logic [15:0] clr_q, clr_d;

  logic        req_state;
  logic        mem_fire;
  logic        rd_done;
  logic [15:0] shifted;
  logic [7:0]  left_bits;
  logic [7:0]  right_bits;
  logic [15:0] row_base;
  logic [7:0]  rcol;
  logic        right_exists;
  logic [7:0]  y_next;
  logic        y_end;
  logic        unused_bits;

  assign unused_bits = ^{cmd_x_in[7:6], mem_rdata_in[15:8]};

  // {spr,0}>>off splits the sprite across the two destination bytes at once.
  assign shifted    = {spr_q, 8'h00} >> off_q;
  assign left_bits  = shifted[15:8];
  assign right_bits = shifted[7:0];
  assign row_base   = 16'(y_q) * RB16;

`ifdef CHIP8_DRAW_WRAP_EN
  assign rcol         = (col_q == LAST_COL) ? 8'h00 : col_q + 8'h01;
  assign right_exists = 1'b1;
  assign y_next       = (y_q + 8'h01) & Y_MASK;
  assign y_end        = 1'b0;
`else
  assign rcol         = col_q + 8'h01;
  assign right_exists = (col_q != LAST_COL);
  assign y_next       = y_q + 8'h01;
  assign y_end        = ({1'b0, y_q} + 9'd1) >= SH9;
`endif

  assign req_state = (state_q == S_SPR_RD) || (state_q == S_L_RD) ||
                     (state_q == S_L_WR)   || (state_q == S_R_RD) ||
                     (state_q == S_R_WR)   || (state_q == S_CLR_WR);

  // Outputs are gated by rst_in so they read idle for the whole reset window.
  assign mem_valid_out = rst_in && req_state && !acc_q;
  assign mem_we_out    = rst_in && ((state_q == S_L_WR) || (state_q == S_R_WR) ||
                                    (state_q == S_CLR_WR));
  assign mem_type_out  = (state_q != S_SPR_RD);
  assign cmd_ready_out = rst_in && (state_q == S_IDLE);
  assign done_out      = rst_in && (state_q == S_FINISH);
  assign collision_out = rst_in && coll_q;
  assign mem_fire      = mem_valid_out && mem_ready_in;
  assign rd_done       = acc_q && mem_rvalid_in;

  always_comb begin
    mem_addr_out = 16'h0000;
    mem_data_out = 16'h0000;
    case (state_q)
      S_SPR_RD: mem_addr_out = {4'h0, iaddr_q};
      S_L_RD:   mem_addr_out = row_base + {8'h00, col_q};
      S_L_WR: begin
        mem_addr_out = row_base + {8'h00, col_q};
        mem_data_out = {8'h00, vdat_q ^ left_bits};
      end
      S_R_RD:   mem_addr_out = row_base + {8'h00, rcol};
      S_R_WR: begin
        mem_addr_out = row_base + {8'h00, rcol};
        mem_data_out = {8'h00, vdat_q ^ right_bits};
      end
      S_CLR_WR: mem_addr_out = clr_q;
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    coll_d  = coll_q;
    col_d   = col_q;
    off_d   = off_q;
    y_d     = y_q;
    rows_d  = rows_q;
    iaddr_d = iaddr_q;
    spr_d   = spr_q;
    vdat_d  = vdat_q;
    clr_d   = clr_q;

    // a write or a read acceptance ends the request phase; reads then wait
    if (mem_fire && !mem_we_out) acc_d = 1'b1;
    if (rd_done) acc_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid_in) begin
          coll_d  = 1'b0;
          col_d   = {5'b00000, cmd_x_in[5:3]};
          off_d   = cmd_x_in[2:0];
          y_d     = cmd_y_in & Y_MASK;
          rows_d  = cmd_n_in;
          iaddr_d = cmd_i_in;
          clr_d   = 16'h0000;
          if (cmd_op_in)              state_d = S_CLR_WR;
          else if (cmd_n_in == 4'd0)  state_d = S_FINISH;
          else                        state_d = S_SPR_RD;
        end
      end
      S_SPR_RD: begin
        if (rd_done) begin
          spr_d   = mem_rdata_in[7:0];
          state_d = S_L_RD;
        end
      end
      S_L_RD: begin
        if (rd_done) begin
          vdat_d  = mem_rdata_in[7:0];
          state_d = S_L_WR;
        end
      end
      S_R_RD: begin
        if (rd_done) begin
          vdat_d  = mem_rdata_in[7:0];
          state_d = S_R_WR;
        end
      end
      S_L_WR, S_R_WR: begin
        if (mem_fire) begin
          if (state_q == S_L_WR) coll_d = coll_q | (|(vdat_q & left_bits));
          else                   coll_d = coll_q | (|(vdat_q & right_bits));
          if (state_q == S_L_WR && off_q != 3'd0 && right_exists) begin
            state_d = S_R_RD;
          end else if (rows_q == 4'd1 || y_end) begin
            state_d = S_FINISH;
          end else begin
            rows_d  = rows_q - 4'd1;
            y_d     = y_next;
            iaddr_d = iaddr_q + 12'd1;
            state_d = S_SPR_RD;
          end
        end
      end
      S_CLR_WR: begin
        if (mem_fire) begin
          if (clr_q == CLR_LAST) state_d = S_FINISH;
          else                   clr_d   = clr_q + 16'd1;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q <= S_IDLE;
      acc_q   <= 1'b0;
      coll_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      coll_q  <= coll_d;
    end
  end

  always_ff @(posedge clk_in) begin
    col_q   <= col_d;
    off_q   <= off_d;
    y_q     <= y_d;
    rows_q  <= rows_d;
    iaddr_q <= iaddr_d;
    spr_q   <= spr_d;
    vdat_q  <= vdat_d;
    clr_q   <= clr_d;
  end

endmodule
